// File: rtl/vga_timing_if.sv
// Raster timing bundle: fetch-side coordinates plus display-side sync/enable/markers.
interface vga_timing_if #(
   parameter int unsigned COORD_W = 11
);
   logic [COORD_W-1:0] pix_x;
   logic [COORD_W-1:0] pix_y;
   logic               pix_valid;
   logic               de;
   logic               hsync;
   logic               vsync;
   logic               line_start;
   logic               frame_start;

   modport master (
      output pix_x, pix_y, pix_valid, de, hsync, vsync, line_start, frame_start
   );

   modport slave (
      input  pix_x, pix_y, pix_valid, de, hsync, vsync, line_start, frame_start
   );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator advancing on a pixel clock-enable.
// Fetch coordinates lead the display-side decode by LOOKAHEAD ce steps.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE  = 800,
   parameter int unsigned H_FP      = 40,
   parameter int unsigned H_SYNC    = 128,
   parameter int unsigned H_BP      = 88,
   parameter int unsigned V_ACTIVE  = 600,
   parameter int unsigned V_FP      = 1,
   parameter int unsigned V_SYNC    = 4,
   parameter int unsigned V_BP      = 23,
   parameter int unsigned H_POL     = 1,
   parameter int unsigned V_POL     = 1,
   parameter int unsigned LOOKAHEAD = 0,
   parameter int unsigned COORD_W   = 11
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         ce,
   vga_timing_if.master vid
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
   localparam int unsigned HS_END  = HS_BEG + H_SYNC;
   localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
   localparam int unsigned VS_END  = VS_BEG + V_SYNC;

   // Display-side word: {frame_start, line_start, vsync, hsync, de}
   localparam int unsigned DW   = 5;
   localparam int unsigned B_DE = 0;
   localparam int unsigned B_HS = 1;
   localparam int unsigned B_VS = 2;
   localparam int unsigned B_LS = 3;
   localparam int unsigned B_FS = 4;
   localparam logic [DW-1:0] IDLE = {1'b0, 1'b0, (V_POL == 0), (H_POL == 0), 1'b0};

   // Elaboration-time parameter sanity
   if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_porch
      $error("vga_timing_gen: porch and sync widths must be >= 1");
   end
   if ((H_TOTAL >> COORD_W) != 0 || (V_TOTAL >> COORD_W) != 0) begin : g_bad_width
      $error("vga_timing_gen: COORD_W too small for H_TOTAL/V_TOTAL");
   end
   if (LOOKAHEAD > 15) begin : g_bad_look
      $error("vga_timing_gen: LOOKAHEAD must be <= 15");
   end

   logic [COORD_W-1:0] h;
   logic [COORD_W-1:0] v;
   logic               h_last;
   logic               v_last;
   logic               hs_on;
   logic               vs_on;
   logic [DW-1:0]      disp_c;
   logic [DW-1:0]      disp_dly;

   assign h_last = (h == COORD_W'(H_TOTAL - 1));
   assign v_last = (v == COORD_W'(V_TOTAL - 1));

   // Raster position counters; h is the position the next ce edge presents
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         h <= '0;
         v <= '0;
      end else if (ce) begin
         h <= h_last ? '0 : h + COORD_W'(1);
         if (h_last) begin
            v <= v_last ? '0 : v + COORD_W'(1);
         end
      end
   end

   // Decode of the current position into the display-side word
   always_comb begin
      disp_c       = IDLE;
      hs_on        = (h >= COORD_W'(HS_BEG)) && (h < COORD_W'(HS_END));
      vs_on        = (v >= COORD_W'(VS_BEG)) && (v < COORD_W'(VS_END));
      disp_c[B_DE] = (h < COORD_W'(H_ACTIVE)) && (v < COORD_W'(V_ACTIVE));
      disp_c[B_HS] = hs_on ^ (H_POL == 0);
      disp_c[B_VS] = vs_on ^ (V_POL == 0);
      disp_c[B_LS] = (h == '0) && (v < COORD_W'(V_ACTIVE));
      disp_c[B_FS] = (h == '0) && (v == '0);
   end

   // Fetch-side outputs follow the counters on every ce edge
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         vid.pix_x     <= '0;
         vid.pix_y     <= '0;
         vid.pix_valid <= 1'b0;
      end else if (ce) begin
         vid.pix_x     <= h;
         vid.pix_y     <= v;
         vid.pix_valid <= disp_c[B_DE];
      end
   end

   if (LOOKAHEAD == 0) begin : g_no_dly
      assign disp_dly = disp_c;
   end else begin : g_dly
      logic [DW-1:0] sr [LOOKAHEAD];

      // ce-gated delay line, primed with blanking values on reset
      always_ff @(posedge clk or negedge clr_n) begin
         if (!clr_n) begin
            for (int i = 0; i < int'(LOOKAHEAD); i++) begin
               sr[i] <= IDLE;
            end
         end else if (ce) begin
            sr[0] <= disp_c;
            for (int i = 1; i < int'(LOOKAHEAD); i++) begin
               sr[i] <= sr[i-1];
            end
         end
      end

      assign disp_dly = sr[LOOKAHEAD-1];
   end

   // Display-side registers; markers are single-clk pulses after a ce edge
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         vid.de          <= 1'b0;
         vid.hsync       <= IDLE[B_HS];
         vid.vsync       <= IDLE[B_VS];
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
      end else if (ce) begin
         vid.de          <= disp_dly[B_DE];
         vid.hsync       <= disp_dly[B_HS];
         vid.vsync       <= disp_dly[B_VS];
         vid.line_start  <= disp_dly[B_LS];
         vid.frame_start <= disp_dly[B_FS];
      end else begin
         vid.line_start  <= 1'b0;
         vid.frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four configurations checked every clk against a
// position-count reference model.
module tb_vga_timing_gen;

   typedef struct {
      int ha, hf, hs, hb, va, vf, vs, vb, hp, vp, la;
   } mode_t;

   typedef struct {
      int x, y;
      bit pv, de, hs, vs, ls, fs;
   } exp_t;

   mode_t m_d0 = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 0};
   mode_t m_d3 = '{800, 40, 128, 88, 600, 1, 4, 23, 1, 1, 3};
   mode_t m_s0 = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 0};
   mode_t m_sf = '{8, 2, 2, 2, 4, 1, 1, 1, 0, 0, 15};

   logic clk   = 1'b0;
   logic clr_n = 1'b0;
   logic ce_d  = 1'b0;
   logic ce_s  = 1'b0;

   int n_checks = 0;
   int n_err    = 0;
   int k_d      = 0;
   int k_s      = 0;
   bit cl_d     = 1'b0;
   bit cl_s     = 1'b0;

   always #5 clk = ~clk;

   vga_timing_if #(.COORD_W(11)) d0_if ();
   vga_timing_if #(.COORD_W(11)) d3_if ();
   vga_timing_if #(.COORD_W(4))  s0_if ();
   vga_timing_if #(.COORD_W(4))  sf_if ();

   vga_timing_gen #(.LOOKAHEAD(0)) u_d0 (.clk(clk), .clr_n(clr_n), .ce(ce_d), .vid(d0_if.master));
   vga_timing_gen #(.LOOKAHEAD(3)) u_d3 (.clk(clk), .clr_n(clr_n), .ce(ce_d), .vid(d3_if.master));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(0), .V_POL(0), .LOOKAHEAD(0), .COORD_W(4)
   ) u_s0 (.clk(clk), .clr_n(clr_n), .ce(ce_s), .vid(s0_if.master));

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .H_POL(0), .V_POL(0), .LOOKAHEAD(15), .COORD_W(4)
   ) u_sf (.clk(clk), .clr_n(clr_n), .ce(ce_s), .vid(sf_if.master));

   // Expected outputs after k ce steps since reset; ce_last = ce seen at the latest edge
   function automatic exp_t model(mode_t m, int k, bit ce_last);
      exp_t e;
      int ht, vt, idx, hd, vd, kd;
      ht = m.ha + m.hf + m.hs + m.hb;
      vt = m.va + m.vf + m.vs + m.vb;
      e.x = 0; e.y = 0; e.pv = 1'b0;
      if (k > 0) begin
         idx  = (k - 1) % (ht * vt);
         e.x  = idx % ht;
         e.y  = idx / ht;
         e.pv = (e.x < m.ha) && (e.y < m.va);
      end
      kd   = k - m.la;
      e.de = 1'b0;
      e.hs = (m.hp == 0);
      e.vs = (m.vp == 0);
      e.ls = 1'b0;
      e.fs = 1'b0;
      if (kd > 0) begin
         idx  = (kd - 1) % (ht * vt);
         hd   = idx % ht;
         vd   = idx / ht;
         e.de = (hd < m.ha) && (vd < m.va);
         e.hs = ((hd >= m.ha + m.hf) && (hd < m.ha + m.hf + m.hs)) ? (m.hp != 0) : (m.hp == 0);
         e.vs = ((vd >= m.va + m.vf) && (vd < m.va + m.vf + m.vs)) ? (m.vp != 0) : (m.vp == 0);
         e.ls = ce_last && (hd == 0) && (vd < m.va);
         e.fs = ce_last && (hd == 0) && (vd == 0);
      end
      return e;
   endfunction

   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic chk_dut(string n, exp_t e, logic [31:0] x, logic [31:0] y,
                          logic pv, logic de, logic hs, logic vs, logic ls, logic fs);
      chk({n, ".pix_x"},       x,           32'(e.x));
      chk({n, ".pix_y"},       y,           32'(e.y));
      chk({n, ".pix_valid"},   32'(pv),     32'(e.pv));
      chk({n, ".de"},          32'(de),     32'(e.de));
      chk({n, ".hsync"},       32'(hs),     32'(e.hs));
      chk({n, ".vsync"},       32'(vs),     32'(e.vs));
      chk({n, ".line_start"},  32'(ls),     32'(e.ls));
      chk({n, ".frame_start"}, 32'(fs),     32'(e.fs));
   endtask

   task automatic check_all();
      chk_dut("d0", model(m_d0, k_d, cl_d), 32'(d0_if.pix_x), 32'(d0_if.pix_y), d0_if.pix_valid,
              d0_if.de, d0_if.hsync, d0_if.vsync, d0_if.line_start, d0_if.frame_start);
      chk_dut("d3", model(m_d3, k_d, cl_d), 32'(d3_if.pix_x), 32'(d3_if.pix_y), d3_if.pix_valid,
              d3_if.de, d3_if.hsync, d3_if.vsync, d3_if.line_start, d3_if.frame_start);
      chk_dut("s0", model(m_s0, k_s, cl_s), 32'(s0_if.pix_x), 32'(s0_if.pix_y), s0_if.pix_valid,
              s0_if.de, s0_if.hsync, s0_if.vsync, s0_if.line_start, s0_if.frame_start);
      chk_dut("sf", model(m_sf, k_s, cl_s), 32'(sf_if.pix_x), 32'(sf_if.pix_y), sf_if.pix_valid,
              sf_if.de, sf_if.hsync, sf_if.vsync, sf_if.line_start, sf_if.frame_start);
   endtask

   // One clk: advance the model by what the DUTs saw at the edge, then compare
   task automatic step();
      @(posedge clk);
      if (clr_n) begin
         if (ce_d) k_d++;
         if (ce_s) k_s++;
         cl_d = ce_d;
         cl_s = ce_s;
      end else begin
         k_d = 0; k_s = 0; cl_d = 1'b0; cl_s = 1'b0;
      end
      #1;
      check_all();
   endtask

   initial begin
      int guard;

      // Reset held with ce toggling
      #3;
      for (int i = 0; i < 6; i++) begin
         ce_d = ~ce_d;
         ce_s = ~ce_s;
         step();
      end

      // Continuous ce on the default modes, random ce on the small modes
      clr_n = 1'b1;
      for (int i = 0; i < 2300; i++) begin
         ce_d = 1'b1;
         ce_s = 1'($urandom_range(0, 1));
         step();
      end

      // ce every third clk on the default modes
      for (int i = 0; i < 3400; i++) begin
         ce_d = (i % 3 == 0);
         ce_s = ($urandom_range(0, 3) != 0);
         step();
      end

      // Run the default mode to pix_x = 500, then reset asynchronously mid-line
      guard = 0;
      ce_d  = 1'b1;
      while (!(k_d > 0 && (k_d - 1) % 1056 == 500) && guard < 2000) begin
         ce_s = 1'($urandom_range(0, 1));
         step();
         guard++;
      end
      chk("seek_h500", 32'(guard < 2000), 32'(1));
      clr_n = 1'b0;
      #2;
      k_d = 0; k_s = 0; cl_d = 1'b0; cl_s = 1'b0;
      check_all();
      for (int i = 0; i < 3; i++) begin
         step();
      end

      // Random ce on everything after release
      clr_n = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         ce_d = 1'($urandom_range(0, 1));
         ce_s = 1'($urandom_range(0, 1));
         step();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/SVGA raster timing generator; successor to the fixed 800x600 timing block in the GPU path.
- Generates hsync, vsync, data-enable and frame/line markers for any mode set by parameters.
- Issues fetch coordinates LOOKAHEAD pixel steps ahead of the display-side signals, which hides framebuffer/char-ROM read latency.
- Advances only on a pixel clock-enable, so it can run from a fast system clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (pixels)
- H_SYNC, 128, horizontal sync width (pixels)
- H_BP, 88, horizontal back porch (pixels)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vertical sync width (lines)
- V_BP, 23, vertical back porch (lines)
- H_POL, 1, hsync active level (1 = positive pulse)
- V_POL, 1, vsync active level
- LOOKAHEAD, 0, display-side delay relative to fetch outputs, in ce steps (0..15)
- COORD_W, 11, counter/coordinate width; must satisfy 2^COORD_W >= max(H_TOTAL, V_TOTAL)

Ports:
- clk  in  1  system clock
- clr_n  in  1  asynchronous active-low reset
- ce  in  1  pixel clock-enable; all state advances only when 1
- pix_x  out  COORD_W  fetch-side horizontal position (raw counter)
- pix_y  out  COORD_W  fetch-side vertical position (raw counter)
- pix_valid  out  1  fetch position is inside the active area
- de  out  1  display-side data enable
- hsync  out  1  horizontal sync, polarity H_POL
- vsync  out  1  vertical sync, polarity V_POL
- line_start  out  1  one-clk pulse at the first pixel of each active line (display side)
- frame_start  out  1  one-clk pulse at pixel (0,0) (display side)

Behaviour:
- Interface decision: one clock (clk); reset is asynchronous and active-low (clr_n).
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 1056); V_TOTAL likewise (default 628).
- Line order: active, front porch, sync, back porch. Counter 0 is the first visible pixel/line.
- Counters h, v update only on clk edges where ce=1.
  - h increments; at h = H_TOTAL-1 it wraps to 0 and v increments.
  - v wraps to 0 after V_TOTAL-1, on the same edge that h wraps.
- Fetch outputs are registered on every ce edge:
  - pix_x = h and pix_y = v (full range, including blanking).
  - pix_valid = (h < H_ACTIVE) && (v < V_ACTIVE).
- Display-side decode for position (h,v):
  - de = pix_valid.
  - hsync = H_POL when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, else !H_POL.
  - vsync = V_POL when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, else !V_POL. Evaluated per line only.
- Display-side alignment:
  - de, hsync and vsync for position (h,v) appear LOOKAHEAD ce-steps after pix_x/pix_y/pix_valid show (h,v).
  - The delay line is a LOOKAHEAD-deep shift register that shifts only on ce.
  - LOOKAHEAD=0: all outputs are aligned; no delay registers are synthesised.
- Pulses:
  - line_start asserts when display-side position has h=0 and v<V_ACTIVE.
  - frame_start asserts at display-side (0,0).
  - Each pulse is high for exactly one clk cycle, on the clk after the ce edge that produced the position, even if ce stays low afterwards.
- ce=0: every output other than the pulses holds its value; counters and the delay line freeze.
- Reset (async assert, any time, including mid-frame):
  - h=v=0, pix_x=pix_y=0, pix_valid=0, de=0.
  - hsync=!H_POL, vsync=!V_POL, pulses=0.
  - Delay line filled with inactive values.
- After reset release, the first ce edge presents (0,0): pix_valid=1 with LOOKAHEAD=0; with LOOKAHEAD=N, de rises N ce-steps later.
  - frame_start fires for that first (0,0).
- Parameter checks (simulation assertion, elaboration-time): all porch/sync values >= 1, H_TOTAL and V_TOTAL fit in COORD_W, LOOKAHEAD <= 15.

Test Plan:
- Reset values: hold clr_n=0 with ce toggling -> de=0, hsync=0, vsync=0, pix_x=pix_y=0, no pulses.
  - Assert clr_n=0 mid-line at h=500 -> outputs return to reset values immediately (asynchronously).
- Default mode, ce=1 constant, LOOKAHEAD=0:
  - hsync is high for h=840..967 (128 clk) each line; de is high for h=0..799.
  - vsync is high for lines 601..604 exactly; 1056*628 clk per frame between frame_start pulses.
- Wrap: run to (1055,627) -> next ce gives pix_x=0, pix_y=0, pix_valid=1, frame_start for one clk.
  - line_start appears 600 times per frame, never on v>=600.
- LOOKAHEAD=3:
  - pix_valid rises at (0,0) -> de rises exactly 3 ce-steps later.
  - hsync leading edge lags pix_x=840 by 3 ce-steps.
- ce=1 every third clk:
  - Line period = 3168 clk; outputs are stable during ce=0 gaps.
  - frame_start is one clk wide, not three.
- Small mode (H 8/2/2/2, V 4/1/1/1, H_POL=V_POL=0, COORD_W=4):
  - Full frame = 14*7 = 98 ce-steps; hsync low at h=10..11; vsync low on line 5.
  - Exhaustive compare against a reference model over 3 frames.
